pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_en_reg.sv | 21 ++
 rtl/pipe_skid_stage.sv | 117 +++++++++++
 tb/tb_pipe_skid_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: skid stage state encoding and default payload width.
package pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_en_reg.sv
// WIDTH-bit load-enable register with asynchronous active-high reset to RESET_VALUE.
module pipe_en_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage with fully registered handshake outputs.
// Optional synchronous flush port is compiled in with PIPE_SKID_FLUSH_EN.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef PIPE_SKID_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  state_e           state_q;
  state_e           state_d;
  logic             main_en;
  logic             skid_en;
  logic             main_from_skid;
  logic             flush_c;
  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

`ifdef PIPE_SKID_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // Handshake outputs decode registered state only.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = 2'(state_q);

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign main_d   = main_from_skid ? skid_q : in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_en = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_en = 1'b1;
        end else if (in_xfer) begin
          skid_en = 1'b1;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides every transition; data registers may still load harmlessly.
    if (flush_c) begin
      state_d = EMPTY;
    end
  end

  pipe_en_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (out_data)
  );

  pipe_en_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus random valid/ready
// traffic at WIDTH=8 and WIDTH=64 against a queue-based reference model.
module tb_pipe_skid_stage;

  localparam logic [7:0]  RV8  = 8'hA5;
  localparam logic [63:0] RV64 = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, flush8;
  logic [7:0]  in_data8, out_data8;
  logic [1:0]  occ8;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, flush64;
  logic [63:0] in_data64, out_data64;
  logic [1:0]  occ64;

  logic [63:0] q8[$];
  logic [63:0] q64[$];
  bit          last_ix8;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(8), .RESET_VALUE(RV8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_data   (in_data8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_data  (out_data8),
    .occupancy (occ8)
`ifdef PIPE_SKID_FLUSH_EN
    ,
    .flush     (flush8)
`endif
  );

  pipe_skid_stage #(.WIDTH(64), .RESET_VALUE(RV64)) dut64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid64),
    .in_ready  (in_ready64),
    .in_data   (in_data64),
    .out_valid (out_valid64),
    .out_ready (out_ready64),
    .out_data  (out_data64),
    .occupancy (occ64)
`ifdef PIPE_SKID_FLUSH_EN
    ,
    .flush     (flush64)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Observable behaviour follows from the queue: capacity 2, head is out_data.
  task automatic check_model();
    check("occ8", 64'(occ8), 64'(q8.size()));
    check("in_ready8", 64'(in_ready8), 64'(q8.size() < 2));
    check("out_valid8", 64'(out_valid8), 64'(q8.size() > 0));
    if (q8.size() > 0) check("out_data8", 64'(out_data8), q8[0]);
    check("occ64", 64'(occ64), 64'(q64.size()));
    check("in_ready64", 64'(in_ready64), 64'(q64.size() < 2));
    check("out_valid64", 64'(out_valid64), 64'(q64.size() > 0));
    if (q64.size() > 0) check("out_data64", out_data64, q64[0]);
  endtask

  // Advance one clock: apply transfer rules to the model, then check at the falling edge.
  task automatic cycle_all();
    int n8, n64;
    bit ox8, ix8, ox64, ix64;
    @(posedge clk);
    n8   = q8.size();
    n64  = q64.size();
    ox8  = (n8 > 0) && out_ready8;
    ix8  = (n8 < 2) && in_valid8;
    ox64 = (n64 > 0) && out_ready64;
    ix64 = (n64 < 2) && in_valid64;
    last_ix8 = ix8;
    if (rst || flush8) begin
      q8.delete();
    end else begin
      if (ox8) void'(q8.pop_front());
      if (ix8) q8.push_back(64'(in_data8));
    end
    if (rst || flush64) begin
      q64.delete();
    end else begin
      if (ox64) void'(q64.pop_front());
      if (ix64) q64.push_back(in_data64);
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    logic [7:0] bp_exp [3];
    int         idx;
    bit         c_done;
    bp_exp = '{8'h0A, 8'h0B, 8'h0C};

    rst = 1'b1;
    in_valid8 = 1'b0;  in_data8 = '0;  out_ready8 = 1'b0;  flush8 = 1'b0;
    in_valid64 = 1'b0; in_data64 = '0; out_ready64 = 1'b0; flush64 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_data8", 64'(out_data8), 64'(RV8));
    check("rst_out_valid8", 64'(out_valid8), 64'(0));
    check("rst_in_ready8", 64'(in_ready8), 64'(1));
    check("rst_occ8", 64'(occ8), 64'(0));
    check("rst_out_data64", out_data64, RV64);
    rst = 1'b0;
    cycle_all();
    check("idle_out_data8", 64'(out_data8), 64'(RV8));

    // Streaming at full rate.
    out_ready8 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid8 = 1'b1;
      in_data8  = 8'(i);
      cycle_all();
      check("stream_data", 64'(out_data8), 64'(i));
      check("stream_occ", 64'(occ8), 64'(1));
    end
    in_valid8 = 1'b0;
    cycle_all();

    // Backpressure fills the skid slot, third word held off until drained.
    out_ready8 = 1'b0;
    in_valid8 = 1'b1;
    in_data8 = 8'h0A; cycle_all();
    in_data8 = 8'h0B; cycle_all();
    check("bp_occ_full", 64'(occ8), 64'(2));
    check("bp_in_ready", 64'(in_ready8), 64'(0));
    in_data8 = 8'h0C; cycle_all();
    check("bp_held_off", 64'(occ8), 64'(2));
    out_ready8 = 1'b1;
    idx = 0;
    c_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid8 && idx < 3) begin
        check("bp_order", 64'(out_data8), 64'(bp_exp[idx]));
        idx++;
      end
      in_valid8 = !c_done;
      cycle_all();
      if (last_ix8) c_done = 1'b1;
    end
    check("bp_count", 64'(idx), 64'(3));
    in_valid8 = 1'b0;

    // Stall hold.
    out_ready8 = 1'b0;
    in_valid8 = 1'b1;
    in_data8 = 8'h55;
    cycle_all();
    in_valid8 = 1'b0;
    repeat (5) begin
      cycle_all();
      check("stall_data", 64'(out_data8), 64'h55);
      check("stall_valid", 64'(out_valid8), 64'(1));
    end
    out_ready8 = 1'b1;
    cycle_all();

`ifdef PIPE_SKID_FLUSH_EN
    out_ready8 = 1'b0;
    in_valid8 = 1'b1;
    in_data8 = 8'h07; cycle_all();
    in_data8 = 8'h08; cycle_all();
    check("flush_pre_occ", 64'(occ8), 64'(2));
    flush8 = 1'b1;
    in_data8 = 8'h09;
    cycle_all();
    check("flush_occ", 64'(occ8), 64'(0));
    check("flush_valid", 64'(out_valid8), 64'(0));
    flush8 = 1'b0;
    in_data8 = 8'h10;
    cycle_all();
    check("flush_next_word", 64'(out_data8), 64'h10);
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    cycle_all();
`endif

    // Asynchronous reset while full.
    out_ready8 = 1'b0;
    in_valid8 = 1'b1;
    in_data8 = 8'h31; cycle_all();
    in_data8 = 8'h32; cycle_all();
    check("mid_pre_occ", 64'(occ8), 64'(2));
    in_valid8 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid8), 64'(0));
    check("mid_rst_ready", 64'(in_ready8), 64'(1));
    check("mid_rst_occ", 64'(occ8), 64'(0));
    check("mid_rst_data", 64'(out_data8), 64'(RV8));
    q8.delete();
    q64.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle_all();

    // Random valid/ready traffic on both widths.
    for (int c = 0; c < 1000; c++) begin
      in_valid8   = ($urandom_range(0, 3) != 0);
      in_data8    = 8'($urandom);
      out_ready8  = ($urandom_range(0, 2) != 0);
      in_valid64  = ($urandom_range(0, 1) != 0);
      in_data64   = {$urandom, $urandom};
      out_ready64 = ($urandom_range(0, 3) == 0) ? 1'b0 : ($urandom_range(0, 1) != 0);
      cycle_all();
      check("occ_max8", 64'(occ8 <= 2'd2), 64'(1));
      check("occ_max64", 64'(occ64 <= 2'd2), 64'(1));
    end
    in_valid8 = 1'b0;  out_ready8 = 1'b1;
    in_valid64 = 1'b0; out_ready64 = 1'b1;
    repeat (3) cycle_all();
    check("drained8", 64'(occ8), 64'(0));
    check("drained64", 64'(occ64), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
